// File: rtl/fifo_ssd_pkg.sv
// Shared constants for the FIFO display feeder: data width, display field layout
// and the helper that packs FIFO state into the 32-bit display word.
package fifo_ssd_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam int unsigned DispLastPoppedLsb  = 24;
  localparam int unsigned DispHeadLsb        = 16;
  localparam int unsigned DispLastPushedLsb  = 8;
  localparam int unsigned DispCountLsb       = 4;
  localparam int unsigned DispFlagsLsb       = 0;

  localparam int unsigned FlagOverflow  = 3;
  localparam int unsigned FlagUnderflow = 2;
  localparam int unsigned FlagFull      = 1;
  localparam int unsigned FlagEmpty     = 0;

  function automatic logic [31:0] pack_display(
    input logic [DATA_WIDTH-1:0] last_popped,
    input logic [DATA_WIDTH-1:0] head,
    input logic [DATA_WIDTH-1:0] last_pushed,
    input logic [3:0]            count,
    input logic                  overflow,
    input logic                  underflow,
    input logic                  full,
    input logic                  empty
  );
    logic [31:0] word;
    word = '0;
    word[DispLastPoppedLsb +: DATA_WIDTH] = last_popped;
    word[DispHeadLsb +: DATA_WIDTH]       = head;
    word[DispLastPushedLsb +: DATA_WIDTH] = last_pushed;
    word[DispCountLsb +: 4]               = count;
    word[DispFlagsLsb + FlagOverflow]     = overflow;
    word[DispFlagsLsb + FlagUnderflow]    = underflow;
    word[DispFlagsLsb + FlagFull]         = full;
    word[DispFlagsLsb + FlagEmpty]        = empty;
    return word;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge pulse for one raw push button.
module button_debouncer #(
  parameter int unsigned DebounceCycles = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned        CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0]    CntLast = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/fifo_ssd_feeder.sv
// Debounced push/pop buttons driving an 8-entry byte FIFO whose state is packed into
// a registered 32-bit word for the seven-segment display manager.
module fifo_ssd_feeder #(
  parameter int unsigned DATA_WIDTH      = fifo_ssd_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  fifo_ssd_feeder_clk,
  input  logic                  fifo_ssd_feeder_rst,
  input  logic                  fifo_ssd_feeder_port_push_btn,
  input  logic                  fifo_ssd_feeder_port_pop_btn,
  input  logic [DATA_WIDTH-1:0] fifo_ssd_feeder_port_data_in,
  output logic [31:0]           fifo_ssd_feeder_oport_display,
  output logic                  fifo_ssd_feeder_oport_full,
  output logic                  fifo_ssd_feeder_oport_empty
);

  import fifo_ssd_pkg::*;

  localparam int unsigned     PtrW      = $clog2(DEPTH);
  localparam int unsigned     CntW      = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic push_req, pop_req;

  button_debouncer #(.DebounceCycles(DEBOUNCE_CYCLES)) u_push_debouncer (
    .clk_i  (fifo_ssd_feeder_clk),
    .rst_i  (fifo_ssd_feeder_rst),
    .btn_i  (fifo_ssd_feeder_port_push_btn),
    .pulse_o(push_req)
  );

  button_debouncer #(.DebounceCycles(DEBOUNCE_CYCLES)) u_pop_debouncer (
    .clk_i  (fifo_ssd_feeder_clk),
    .rst_i  (fifo_ssd_feeder_rst),
    .btn_i  (fifo_ssd_feeder_port_pop_btn),
    .pulse_o(pop_req)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] last_pushed_q, last_pushed_d, last_popped_q, last_popped_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [31:0]           display_q, display_d;
  logic                  is_full, is_empty, do_push, do_pop;
  logic [DATA_WIDTH-1:0] head;

  assign is_full  = (count_q == FullCount);
  assign is_empty = (count_q == '0);

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    last_pushed_d = last_pushed_q;
    last_popped_d = last_popped_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;

    // A simultaneous pop frees the slot, so a push into a full FIFO still goes ahead.
    do_push = push_req & (~is_full | pop_req);
    do_pop  = pop_req & ~is_empty;

    if (push_req && !pop_req && is_full)  overflow_d  = 1'b1;
    if (pop_req && !push_req && is_empty) underflow_d = 1'b1;

    if (do_push) begin
      mem_d[wr_ptr_q] = fifo_ssd_feeder_port_data_in;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
      last_pushed_d   = fifo_ssd_feeder_port_data_in;
    end
    if (do_pop) begin
      last_popped_d = mem_q[rd_ptr_q];
      rd_ptr_d      = rd_ptr_q + PtrW'(1);
    end

    if (do_push && !do_pop)      count_d = count_q + CntW'(1);
    else if (do_pop && !do_push) count_d = count_q - CntW'(1);

    // Display tracks the post-update state so it is current one cycle after the request.
    head      = (count_d != '0) ? mem_d[rd_ptr_d] : '0;
    display_d = pack_display(last_popped_d, head, last_pushed_d, 4'(count_d),
                             overflow_d, underflow_d, count_d == FullCount, count_d == '0);
  end

  always_ff @(posedge fifo_ssd_feeder_clk) begin
    if (fifo_ssd_feeder_rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_pushed_q <= '0;
      last_popped_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      display_q     <= 32'h0000_0001;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_pushed_q <= last_pushed_d;
      last_popped_q <= last_popped_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      display_q     <= display_d;
    end
  end

  // Storage needs no reset; contents are only observable through count-qualified reads.
  always_ff @(posedge fifo_ssd_feeder_clk) begin
    mem_q <= mem_d;
  end

  assign fifo_ssd_feeder_oport_display = display_q;
  assign fifo_ssd_feeder_oport_full    = is_full;
  assign fifo_ssd_feeder_oport_empty   = is_empty;

endmodule
